// File: rtl/lpor_adder_lock_checker_if.sv
// Beat stream from the locked/oracle adder pair into the lock checker.
// The checker is the slave: it returns in_ready and consumes both results.
interface lpor_adder_lock_checker_if #(
    parameter int WIDTH = 33
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] locked_result;
    logic [WIDTH-1:0] oracle_result;

    modport master (
        output in_valid,
        output locked_result,
        output oracle_result,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  locked_result,
        input  oracle_result,
        output in_ready
    );
endinterface

// File: rtl/lpor_adder_lock_checker.sv
// Corruption-statistics checker for the XOR-locked lower-part-OR adder.
// Two-stage pipeline: S1 registers the diff vector, S2 folds it into the run statistics.
module lpor_adder_lock_checker #(
    parameter int WIDTH = 33,
    parameter int CNT_W = 32,
    parameter int HD_W  = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [CNT_W-1:0]        num_patterns,
    lpor_adder_lock_checker_if.slave bus,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_W-1:0]        pattern_cnt,
    output logic [CNT_W-1:0]        mismatch_cnt,
    output logic [CNT_W+HD_W-1:0]   bit_err_total,
    output logic [WIDTH-1:0]        err_bit_mask,
    output logic                    first_fail_valid,
    output logic [CNT_W-1:0]        first_fail_idx
);
    localparam int TOT_W = CNT_W + HD_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_start_ok;
    logic               w_accept;
    logic               w_last;
    logic               w_ready_nxt;

    logic               r_in_ready;
    logic               r_busy;
    logic               r_done;
    logic [CNT_W-1:0]   r_num;
    logic [CNT_W-1:0]   r_pattern_cnt;
    logic [CNT_W-1:0]   r_mismatch_cnt;
    logic [TOT_W-1:0]   r_bit_err_total;
    logic [WIDTH-1:0]   r_err_bit_mask;
    logic               r_first_fail_valid;
    logic [CNT_W-1:0]   r_first_fail_idx;

    logic               r_vld_p1;
    logic [WIDTH-1:0]   r_diff_p1;
    logic [CNT_W-1:0]   r_idx_p1;
    logic [HD_W-1:0]    w_hd_p1;

    function automatic logic [HD_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [HD_W-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + HD_W'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [TOT_W-1:0] sat_add(input logic [TOT_W-1:0] a,
                                                 input logic [HD_W-1:0]  b);
        logic [TOT_W:0] s;
        s = {1'b0, a} + (TOT_W + 1)'(b);
        return s[TOT_W] ? {TOT_W{1'b1}} : s[TOT_W-1:0];
    endfunction

    assign w_accept = bus.in_valid & r_in_ready;
    assign w_last   = w_accept && (r_pattern_cnt == r_num - CNT_W'(1));
    assign w_hd_p1  = popcount(r_diff_p1);

    always_comb begin
        w_state_nxt = r_state;
        w_start_ok  = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_start_ok  = 1'b1;
                    w_state_nxt = (num_patterns == '0) ? DONE : RUN;
                end else if (r_state == DONE) begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (r_vld_p1) begin
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        // Ready is registered, so it is derived from where the FSM is heading.
        w_ready_nxt = (w_state_nxt == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_vld_p1   <= 1'b0;
        end else begin
            r_in_ready <= w_ready_nxt;
            r_busy     <= (w_state_nxt == RUN) || (w_state_nxt == DRAIN);
            r_done     <= (w_state_nxt == DONE);
            r_vld_p1   <= w_accept;
        end
    end

    // S1: capture diff vector and beat index on acceptance
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_diff_p1 <= bus.locked_result ^ bus.oracle_result;
            r_idx_p1  <= r_pattern_cnt;
        end
    end

    // S2: fold the registered diff into the run statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            r_num              <= '0;
            r_pattern_cnt      <= '0;
            r_mismatch_cnt     <= '0;
            r_bit_err_total    <= '0;
            r_err_bit_mask     <= '0;
            r_first_fail_valid <= 1'b0;
            r_first_fail_idx   <= '0;
        end else if (w_start_ok) begin
            r_num              <= num_patterns;
            r_pattern_cnt      <= '0;
            r_mismatch_cnt     <= '0;
            r_bit_err_total    <= '0;
            r_err_bit_mask     <= '0;
            r_first_fail_valid <= 1'b0;
            r_first_fail_idx   <= '0;
        end else begin
            if (w_accept) begin
                r_pattern_cnt <= sat_inc(r_pattern_cnt);
            end
            if (r_vld_p1) begin
                r_bit_err_total <= sat_add(r_bit_err_total, w_hd_p1);
                r_err_bit_mask  <= r_err_bit_mask | r_diff_p1;
                if (w_hd_p1 != '0) begin
                    r_mismatch_cnt <= sat_inc(r_mismatch_cnt);
                    if (!r_first_fail_valid) begin
                        r_first_fail_valid <= 1'b1;
                        r_first_fail_idx   <= r_idx_p1;
                    end
                end
            end
        end
    end

    assign bus.in_ready      = r_in_ready;
    assign busy              = r_busy;
    assign done              = r_done;
    assign pattern_cnt       = r_pattern_cnt;
    assign mismatch_cnt      = r_mismatch_cnt;
    assign bit_err_total     = r_bit_err_total;
    assign err_bit_mask      = r_err_bit_mask;
    assign first_fail_valid  = r_first_fail_valid;
    assign first_fail_idx    = r_first_fail_idx;
endmodule

// File: tb/tb_lpor_adder_lock_checker.sv
// Randomized bench for lpor_adder_lock_checker with a queue-based statistics model.
module tb_lpor_adder_lock_checker;
    localparam int W  = 33;
    localparam int CW = 32;
    localparam int HW = 6;
    localparam int SW = CW + (CW + HW) + W + 1 + CW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              start;
    logic [CW-1:0]     num_patterns;
    logic              busy;
    logic              done;
    logic [CW-1:0]     pattern_cnt;
    logic [CW-1:0]     mismatch_cnt;
    logic [CW+HW-1:0]  bit_err_total;
    logic [W-1:0]      err_bit_mask;
    logic              first_fail_valid;
    logic [CW-1:0]     first_fail_idx;

    lpor_adder_lock_checker_if #(.WIDTH(W)) bus ();

    lpor_adder_lock_checker #(.WIDTH(W), .CNT_W(CW), .HD_W(HW)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .num_patterns     (num_patterns),
        .bus              (bus.slave),
        .busy             (busy),
        .done             (done),
        .pattern_cnt      (pattern_cnt),
        .mismatch_cnt     (mismatch_cnt),
        .bit_err_total    (bit_err_total),
        .err_bit_mask     (err_bit_mask),
        .first_fail_valid (first_fail_valid),
        .first_fail_idx   (first_fail_idx)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] q_lk[$];
    logic [W-1:0] q_orc[$];
    bit           q_vpat[$];

    int acc;
    int last_pres;
    int done_cyc;
    int late_rdy;
    bit busy_seen;

    logic [CW-1:0]    e_mis;
    logic [CW+HW-1:0] e_tot;
    logic [W-1:0]     e_mask;
    logic             e_ffv;
    logic [CW-1:0]    e_ffi;
    logic [SW-1:0]    got_s;
    logic [SW-1:0]    exp_s;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Statistics over the first n beats, straight from the definitions.
    task automatic model(input int n);
        logic [W-1:0] d;
        e_mis  = '0;
        e_tot  = '0;
        e_mask = '0;
        e_ffv  = 1'b0;
        e_ffi  = '0;
        for (int i = 0; i < n; i++) begin
            d      = q_lk[i] ^ q_orc[i];
            e_tot  = e_tot + (CW + HW)'($countones(d));
            e_mask = e_mask | d;
            if (d != '0) begin
                e_mis = e_mis + 1'b1;
                if (!e_ffv) begin
                    e_ffv = 1'b1;
                    e_ffi = CW'(i);
                end
            end
        end
        exp_s = {e_mis, e_tot, e_mask, e_ffv, e_ffi};
    endtask

    task automatic sample_stats();
        got_s = {mismatch_cnt, bit_err_total, err_bit_mask, first_fail_valid, first_fail_idx};
    endtask

    task automatic rand_beats(input int n, input int err_pct);
        logic [W-1:0] o;
        q_lk.delete();
        q_orc.delete();
        for (int i = 0; i < n; i++) begin
            o = {1'($urandom_range(1)), 32'($urandom)};
            q_orc.push_back(o);
            if ($urandom_range(99) < err_pct)
                q_lk.push_back(o ^ {1'($urandom_range(1)), 32'($urandom)});
            else
                q_lk.push_back(o);
        end
    endtask

    // Starts a run and feeds beats until done appears or the budget runs out.
    task automatic drive_run(input int n, input int pct, input int start_at);
        bit v;
        bit rdy;
        start        = 1'b1;
        num_patterns = CW'(n);
        step();
        start        = 1'b0;
        num_patterns = 32'($urandom);
        acc = 0; last_pres = -1; done_cyc = -1; late_rdy = 0; busy_seen = 1'b0;
        if (done) done_cyc = 0;
        if (busy) busy_seen = 1'b1;
        for (int c = 0; c < 2000 && done_cyc < 0; c++) begin
            if (c < q_vpat.size()) v = q_vpat[c];
            else v = ($urandom_range(99) < pct);
            if (acc >= q_lk.size()) v = 1'b0;
            bus.in_valid = v;
            if (v) begin
                bus.locked_result = q_lk[acc];
                bus.oracle_result = q_orc[acc];
            end else begin
                bus.locked_result = {1'b1, 32'($urandom)};
                bus.oracle_result = 33'h0;
            end
            start = (c == start_at);
            if (c == start_at) num_patterns = CW'(1);
            rdy = bus.in_ready;
            if (rdy && acc >= n) late_rdy++;
            step();
            start = 1'b0;
            if (v && rdy) begin
                acc++;
                last_pres = c;
            end
            if (busy) busy_seen = 1'b1;
            if (done) done_cyc = c + 1;
        end
        bus.in_valid = 1'b0;
        n_tests++;
        if (done_cyc < 0) begin
            n_fail++;
            $display("FAIL run_timeout: no done within budget, n=%0d accepted=%0d", n, acc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; num_patterns = '0;
        bus.in_valid = 1'b0; bus.locked_result = '0; bus.oracle_result = '0;
        step(); step();
        rst = 1'b0;
        n_tests++;
        if ({busy, done, bus.in_ready, first_fail_valid} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy/done/ready/ffv=%b expected 0000",
                     {busy, done, bus.in_ready, first_fail_valid});
        end
        n_tests++;
        if (pattern_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_pattern_cnt: got %0d expected 0", pattern_cnt);
        end
        sample_stats();
        n_tests++;
        if (got_s !== '0) begin
            n_fail++;
            $display("FAIL reset_stats: got %h expected 0", got_s);
        end
    endtask

    task automatic test_clean_run();
        q_lk.delete(); q_orc.delete(); q_vpat.delete();
        for (int i = 0; i < 4; i++) begin
            q_lk.push_back(33'h0_1234_5678);
            q_orc.push_back(33'h0_1234_5678);
        end
        drive_run(4, 100, -1);
        n_tests++;
        if (last_pres !== 3 || done_cyc !== last_pres + 2) begin
            n_fail++;
            $display("FAIL clean_latency: last accept %0d done %0d expected 3 and 5", last_pres, done_cyc);
        end
        n_tests++;
        if (pattern_cnt !== 32'd4) begin
            n_fail++;
            $display("FAIL clean_pattern_cnt: got %0d expected 4", pattern_cnt);
        end
        sample_stats();
        n_tests++;
        if (got_s !== '0) begin
            n_fail++;
            $display("FAIL clean_stats: got %h expected 0", got_s);
        end
        step();
        n_tests++;
        if ({done, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL clean_done_pulse: done/busy=%b expected 00", {done, busy});
        end
    endtask

    task automatic test_carry_fault();
        logic [W-1:0] o;
        q_lk.delete(); q_orc.delete(); q_vpat.delete();
        for (int i = 0; i < 8; i++) begin
            o = {1'($urandom_range(1)), 32'($urandom)};
            q_orc.push_back(o);
            q_lk.push_back((i == 2 || i == 5) ? (o ^ 33'h1_0000_0000) : o);
        end
        drive_run(8, 75, -1);
        n_tests++;
        if (pattern_cnt !== 32'd8 || mismatch_cnt !== 32'd2 || bit_err_total !== 38'd2) begin
            n_fail++;
            $display("FAIL carry_counts: pat=%0d mis=%0d tot=%0d expected 8 2 2",
                     pattern_cnt, mismatch_cnt, bit_err_total);
        end
        n_tests++;
        if (err_bit_mask !== 33'h1_0000_0000 || first_fail_valid !== 1'b1 || first_fail_idx !== 32'd2) begin
            n_fail++;
            $display("FAIL carry_mask_idx: mask=%h ffv=%b ffi=%0d expected 100000000 1 2",
                     err_bit_mask, first_fail_valid, first_fail_idx);
        end
    endtask

    task automatic test_inverted();
        logic [W-1:0] o;
        q_lk.delete(); q_orc.delete(); q_vpat.delete();
        o = {1'($urandom_range(1)), 32'($urandom)};
        q_orc.push_back(o);
        q_lk.push_back(~o);
        drive_run(1, 100, -1);
        n_tests++;
        if (bit_err_total !== 38'd33 || mismatch_cnt !== 32'd1 || err_bit_mask !== 33'h1_FFFF_FFFF
            || first_fail_valid !== 1'b1 || first_fail_idx !== 32'd0) begin
            n_fail++;
            $display("FAIL inverted_stats: tot=%0d mis=%0d mask=%h ffv=%b ffi=%0d expected 33 1 1ffffffff 1 0",
                     bit_err_total, mismatch_cnt, err_bit_mask, first_fail_valid, first_fail_idx);
        end
        n_tests++;
        if (done_cyc !== 2) begin
            n_fail++;
            $display("FAIL inverted_latency: done at %0d expected 2", done_cyc);
        end
    endtask

    task automatic test_valid_gaps();
        q_lk.delete(); q_orc.delete(); q_vpat.delete();
        for (int i = 0; i < 6; i++) begin
            q_orc.push_back(33'(i * 7));
            q_lk.push_back(33'(i * 7) ^ ((i == 1) ? 33'h1 : (i == 3) ? 33'h20 : 33'h0));
        end
        q_vpat = '{1, 0, 1, 1, 1, 1};
        drive_run(3, 0, -1);
        q_vpat.delete();
        n_tests++;
        if (acc !== 3 || late_rdy !== 0) begin
            n_fail++;
            $display("FAIL gaps_accepted: accepted=%0d ready_after_last=%0d expected 3 0", acc, late_rdy);
        end
        n_tests++;
        if (pattern_cnt !== 32'd3 || mismatch_cnt !== 32'd1 || err_bit_mask !== 33'h1
            || first_fail_idx !== 32'd1) begin
            n_fail++;
            $display("FAIL gaps_stats: pat=%0d mis=%0d mask=%h ffi=%0d expected 3 1 1 1",
                     pattern_cnt, mismatch_cnt, err_bit_mask, first_fail_idx);
        end
    endtask

    task automatic test_zero_patterns();
        q_lk.delete(); q_orc.delete(); q_vpat.delete();
        drive_run(0, 100, -1);
        n_tests++;
        if (done_cyc !== 0 || busy_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_done: done at %0d busy_seen=%b expected 0 0", done_cyc, busy_seen);
        end
        sample_stats();
        n_tests++;
        if (got_s !== '0 || pattern_cnt !== '0) begin
            n_fail++;
            $display("FAIL zero_stats: stats=%h pat=%0d expected 0 0", got_s, pattern_cnt);
        end
        step();
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_done_pulse: done=%b expected 0", done);
        end
    endtask

    task automatic test_reset_midrun();
        start = 1'b1; num_patterns = 32'd10;
        step();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid      = 1'b1;
            bus.oracle_result = {1'b0, 32'($urandom)};
            bus.locked_result = ~bus.oracle_result;
            step();
        end
        n_tests++;
        if (pattern_cnt !== 32'd2 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_progress: pat=%0d busy=%b expected 2 1", pattern_cnt, busy);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        sample_stats();
        n_tests++;
        if (got_s !== '0 || pattern_cnt !== '0 || {busy, done, bus.in_ready} !== 3'b000) begin
            n_fail++;
            $display("FAIL midrun_reset: stats=%h pat=%0d busy/done/ready=%b expected all 0",
                     got_s, pattern_cnt, {busy, done, bus.in_ready});
        end
        step(); step();
        sample_stats();
        n_tests++;
        if (got_s !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_discard: stats=%h busy=%b expected 0 0", got_s, busy);
        end
        rand_beats(3, 50);
        drive_run(3, 100, -1);
        model(3);
        sample_stats();
        n_tests++;
        if (got_s !== exp_s || pattern_cnt !== 32'd3) begin
            n_fail++;
            $display("FAIL midrun_fresh: stats=%h pat=%0d expected %h 3", got_s, pattern_cnt, exp_s);
        end
    endtask

    task automatic test_start_ignored();
        rand_beats(5, 50);
        q_vpat.delete();
        drive_run(5, 100, 2);
        model(5);
        sample_stats();
        n_tests++;
        if (pattern_cnt !== 32'd5 || acc !== 5 || got_s !== exp_s) begin
            n_fail++;
            $display("FAIL start_ignored: pat=%0d acc=%0d stats=%h expected 5 5 %h",
                     pattern_cnt, acc, got_s, exp_s);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int pct;
        q_vpat.delete();
        for (int r = 0; r < 12; r++) begin
            n   = $urandom_range(16, 1);
            pct = (r % 3 == 0) ? 100 : $urandom_range(100, 30);
            rand_beats(n + 2, 40);
            drive_run(n, pct, -1);
            model(n);
            sample_stats();
            n_tests++;
            if (got_s !== exp_s || pattern_cnt !== CW'(n) || acc !== n || late_rdy !== 0) begin
                n_fail++;
                $display("FAIL b2b_run%0d: stats=%h pat=%0d acc=%0d late=%0d expected %h %0d",
                         r, got_s, pattern_cnt, acc, late_rdy, exp_s, n);
            end
            n_tests++;
            if (done_cyc !== last_pres + 2 || (pct == 100 && last_pres !== n - 1)) begin
                n_fail++;
                $display("FAIL b2b_timing%0d: last accept %0d done %0d n=%0d", r, last_pres, done_cyc, n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_run();
        test_carry_fault();
        test_inverted();
        test_valid_gaps();
        test_zero_patterns();
        test_reset_midrun();
        test_start_ignored();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/lpor_adder_lock_checker.md
Name: lpor_adder_lock_checker

Overview:
- Streaming output checker that sits directly downstream of the XOR-locked 32-bit lower-part-OR ripple-carry adder in the partial-key simulation flow.
- Each beat it takes the 33-bit result of the locked adder (under a candidate key) and the golden oracle result for the same operands.
- Accumulates the corruption statistics that the key-guess evaluation reads:
  - mismatching-pattern count;
  - total Hamming distance;
  - sticky per-output-bit error mask;
  - index of the first failing pattern.
- A run covers a programmed number of patterns and ends with a one-cycle done pulse.

Parameters:
- WIDTH, 33, result width (sum bits plus carry-out).
- CNT_W, 32, width of pattern/mismatch counters and of num_patterns.
- HD_W, 6, width of the per-beat Hamming distance; must satisfy 2^HD_W > WIDTH.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begins a run when sampled high in IDLE or DONE; ignored otherwise.
- num_patterns  in  CNT_W  beats in the run; sampled on the start cycle.
- in_valid  in  1  locked_result/oracle_result valid.
- in_ready  out  1  checker accepts a beat this cycle.
- locked_result  in  WIDTH  result_o of locked adder.
- oracle_result  in  WIDTH  golden adder result.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse, final statistics valid.
- pattern_cnt  out  CNT_W  beats accepted this run.
- mismatch_cnt  out  CNT_W  beats with any differing bit.
- bit_err_total  out  CNT_W+HD_W  sum of per-beat Hamming distances.
- err_bit_mask  out  WIDTH  OR of all diff vectors this run.
- first_fail_valid  out  1  at least one mismatch seen.
- first_fail_idx  out  CNT_W  0-based index of first mismatching beat.

Behaviour:
- Reset: state IDLE; in_ready, busy, done, first_fail_valid = 0; all counters, mask and first_fail_idx = 0; pipeline valid bits cleared. Applies from any state, including mid-run; in-flight beats are discarded.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start:
  - clears all statistics and pattern_cnt;
  - latches num_patterns;
  - goes to RUN, or to DONE with done=1 if num_patterns==0.
- RUN:
  - in_ready = 1 while accepted count < latched num_patterns.
  - A beat is accepted when in_valid & in_ready at a rising edge.
  - Accepting the last beat moves the FSM to DRAIN on the same edge.
- Pipeline:
  - S1 (edge E of acceptance): register diff = locked_result ^ oracle_result, beat index, and a valid bit. pattern_cnt increments at E.
  - S2 (edge E+1):
    - hd = popcount(diff);
    - bit_err_total += hd;
    - mismatch_cnt += (hd!=0);
    - err_bit_mask |= diff;
    - if hd!=0 and !first_fail_valid: first_fail_idx = index, first_fail_valid = 1.
  - Throughput: one beat per cycle; no bubble is required between beats.
- DRAIN → DONE at the edge at which S2 retires the last beat (E+1 of the last beat). done=1 for exactly the cycle following that edge, when final statistics are visible.
- DONE → IDLE on the next edge unless start is high. Statistics hold until the next start or rst.
- start in RUN/DRAIN is ignored; num_patterns changes after the start cycle have no effect.
- Saturation: pattern_cnt, mismatch_cnt and bit_err_total saturate at all-ones; no wrap.
- Inputs are ignored and not counted while in_ready=0, even if in_valid=1.
- All outputs are registered; there is no combinational path from in_valid to in_ready.

Test Plan:
- rst, start with num_patterns=4, 4 beats locked==oracle=33'h0_1234_5678 → done pulse 2 cycles after last accept; pattern_cnt=4, mismatch_cnt=0, bit_err_total=0, err_bit_mask=0, first_fail_valid=0.
- num_patterns=8, beats 2 and 5 have locked=oracle^33'h1_0000_0000 (wrong carry-out key bit) → mismatch_cnt=2, bit_err_total=2, err_bit_mask=33'h1_0000_0000, first_fail_idx=2.
- num_patterns=1, locked=~oracle → bit_err_total=33, mismatch_cnt=1, err_bit_mask=33'h1_FFFF_FFFF, first_fail_idx=0.
- num_patterns=3, in_valid pattern 1,0,1,1,1,1 → exactly 3 beats accepted; in_ready low from cycle after 3rd accept; the 4th valid beat is not counted.
- start with num_patterns=0 → done high the cycle after start, busy never high, all stats 0.
- Run with num_patterns=10; assert rst after 2 beats accepted → next cycle all outputs 0, state IDLE; fresh start runs normally. Also start pulsed during RUN → ignored, counts unchanged.
